// File: rtl/sub_arb_pkg.sv
// Shared types and constants for the two-requester subtractor arbiter.
package sub_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sub_arb_state_t;

    localparam int NUM_REQ = 2;
    localparam int CNT_W   = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-input combinational round-robin grant; prio names the winner when both request.
module rr_arb2
    import sub_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               prio,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = prio ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/sub_arbiter.sv
// Round-robin sequencer sharing one WIDTH-bit subtractor between two requesters.
// Optional macro SUB_SATURATE_EN clamps the result to 0 whenever a borrow occurs.
module sub_arbiter
    import sub_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_borrow,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_borrow,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    sub_arb_state_t state_reg, state_next;
    logic               prio_reg, prio_next;
    logic               gnt_id_reg, gnt_id_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic [WIDTH-1:0]   data_reg, data_next;
    logic               borrow_reg, borrow_next;
    logic [CNT_W-1:0]   ops_done_reg, ops_done_next;
    logic [NUM_REQ-1:0] rsp_valid_reg, rsp_valid_next;

    logic [NUM_REQ-1:0] req_valid, req_ready, rsp_ready, grant;
    logic [WIDTH-1:0]   req_a [NUM_REQ];
    logic [WIDTH-1:0]   req_b [NUM_REQ];
    logic [WIDTH:0]     sub_full;
    logic [WIDTH-1:0]   sub_data;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign req_a[0]  = req0_a;
    assign req_a[1]  = req1_a;
    assign req_b[0]  = req0_b;
    assign req_b[1]  = req1_b;

    rr_arb2 u_rr_arb2 (
        .valid (req_valid),
        .prio  (prio_reg),
        .grant (grant)
    );

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == IDLE) && grant[gi];
        end
    endgenerate

    // The extra top bit of the widened difference is the unsigned borrow.
    assign sub_full = {1'b0, a_reg} - {1'b0, b_reg};
`ifdef SUB_SATURATE_EN
    assign sub_data = sub_full[WIDTH] ? '0 : sub_full[WIDTH-1:0];
`else
    assign sub_data = sub_full[WIDTH-1:0];
`endif

    always_comb begin
        state_next     = state_reg;
        prio_next      = prio_reg;
        gnt_id_next    = gnt_id_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        data_next      = data_reg;
        borrow_next    = borrow_reg;
        ops_done_next  = ops_done_reg;
        rsp_valid_next = rsp_valid_reg;
        case (state_reg)
            IDLE: begin
                if (grant != '0) begin
                    gnt_id_next = grant[1];
                    a_next      = req_a[grant[1]];
                    b_next      = req_b[grant[1]];
                    state_next  = EXEC;
                end
            end
            EXEC: begin
                data_next                  = sub_data;
                borrow_next                = sub_full[WIDTH];
                rsp_valid_next             = '0;
                rsp_valid_next[gnt_id_reg] = 1'b1;
                state_next                 = RESP;
            end
            RESP: begin
                if ((rsp_valid_reg & rsp_ready) != '0) begin
                    rsp_valid_next = '0;
                    ops_done_next  = ops_done_reg + CNT_W'(1);
                    prio_next      = ~gnt_id_reg;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            prio_reg      <= 1'b0;
            gnt_id_reg    <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            data_reg      <= '0;
            borrow_reg    <= 1'b0;
            ops_done_reg  <= '0;
            rsp_valid_reg <= '0;
        end else begin
            state_reg     <= state_next;
            prio_reg      <= prio_next;
            gnt_id_reg    <= gnt_id_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            data_reg      <= data_next;
            borrow_reg    <= borrow_next;
            ops_done_reg  <= ops_done_next;
            rsp_valid_reg <= rsp_valid_next;
        end
    end

    assign req0_ready  = req_ready[0];
    assign req1_ready  = req_ready[1];
    assign rsp0_valid  = rsp_valid_reg[0];
    assign rsp1_valid  = rsp_valid_reg[1];
    assign rsp0_data   = data_reg;
    assign rsp1_data   = data_reg;
    assign rsp0_borrow = borrow_reg;
    assign rsp1_borrow = borrow_reg;
    assign busy        = (state_reg != IDLE);
    assign ops_done    = ops_done_reg;

endmodule
